// File: rtl/store_buffer.sv
// store_buffer
//   In-order store queue between execute and the data-memory stage. Stores are
//   queued at the tail and drained from the head into the memory write port
//   on any cycle without a load. Younger loads are forwarded buffered data, or
//   told to stall when a buffered store only partially overlaps them.
//
// Ports
//   clk, reset_n                          clock, async active-low reset
//   st_valid/st_address/st_data/st_word   store from execute (st_word: 1 = STW)
//   st_ready                              buffer has a free entry
//   ld_valid/ld_address/ld_word           load in the memory stage (1 = LDW)
//   fwd_hit/fwd_data                      load fully served from the buffer
//   ld_conflict                           partial overlap, load must stall
//   mem_address/mem_write_data/mem_word   head entry (0 when empty)
//   mem_memWrite                          head entry written this cycle
//   count                                 number of queued stores
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       st_valid,
  input  logic [31:0]                st_address,
  input  logic [31:0]                st_data,
  input  logic                       st_word,
  output logic                       st_ready,
  input  logic                       ld_valid,
  input  logic [31:0]                ld_address,
  input  logic                       ld_word,
  output logic                       fwd_hit,
  output logic [31:0]                fwd_data,
  output logic                       ld_conflict,
  output logic [31:0]                mem_address,
  output logic [31:0]                mem_write_data,
  output logic                       mem_word,
  output logic                       mem_memWrite,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      addr_d [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [DEPTH-1:0] word_q, word_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  logic push, pop;

  assign st_ready     = (count_q != CW'(DEPTH));
  assign mem_memWrite = (count_q != '0) && !ld_valid;
  assign push         = st_valid && st_ready;
  assign pop          = mem_memWrite;
  assign count        = count_q;

  assign mem_address    = valid_q[head_q] ? addr_q[head_q] : '0;
  assign mem_write_data = valid_q[head_q] ? data_q[head_q] : '0;
  assign mem_word       = valid_q[head_q] ? word_q[head_q] : 1'b0;

  // Push and pop never target the same slot: pop needs count != 0 and push
  // needs count != DEPTH, and head == tail only in those two cases.
  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    word_d  = word_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      addr_d[tail_q]  = st_address;
      data_d[tail_q]  = st_data;
      word_d[tail_q]  = st_word;
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + 1'b1;
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // Forwarding: walk from the head (oldest) towards the tail so the last
  // overlapping entry seen is the youngest one. A load byte at ld_address+i is
  // covered by an entry when (ld_address + i - entry_addr) mod 2^32 falls
  // inside the entry size, which handles address wrap-around for free.
  logic [PW-1:0] idx;
  logic [31:0]   diff;
  logic [31:0]   ent_len;
  logic          ov, cv, in_rng;
  logic          found, sel_cover;
  logic [1:0]    sel_k;
  logic [31:0]   sel_data;
  int            ld_len;

  always_comb begin
    idx       = '0;
    diff      = '0;
    ent_len   = '0;
    ov        = 1'b0;
    cv        = 1'b0;
    in_rng    = 1'b0;
    found     = 1'b0;
    sel_cover = 1'b0;
    sel_k     = '0;
    sel_data  = '0;
    ld_len    = ld_word ? 4 : 1;
    for (int j = 0; j < DEPTH; j++) begin
      idx = head_q + PW'(j);
      if (valid_q[idx]) begin
        diff    = ld_address - addr_q[idx];
        ent_len = word_q[idx] ? 32'd4 : 32'd1;
        ov      = 1'b0;
        cv      = 1'b1;
        for (int i = 0; i < 4; i++) begin
          if (i < ld_len) begin
            in_rng = (diff + 32'(i)) < ent_len;
            ov     = ov | in_rng;
            cv     = cv & in_rng;
          end
        end
        if (ov) begin
          found     = 1'b1;
          sel_cover = cv;
          sel_k     = diff[1:0];
          sel_data  = data_q[idx];
        end
      end
    end
  end

  assign fwd_hit     = ld_valid && found && sel_cover;
  assign ld_conflict = ld_valid && found && !sel_cover;
  // A covering byte entry always has offset 0, so one byte-select serves both sizes.
  assign fwd_data    = !fwd_hit ? 32'h0 :
                       ld_word  ? sel_data : {24'h0, sel_data[{sel_k, 3'b000} +: 8]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int e = 0; e < DEPTH; e++) begin
        addr_q[e] <= '0;
        data_q[e] <= '0;
      end
      word_q  <= '0;
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule
